// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive core.
package uart_rx_pkg;

  localparam int UART_RX_DATA_W       = 8;
  localparam int UART_RX_CLKS_PER_BIT = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Mid-bit sample tick generator: one pulse CLKS_PER_BIT/2 cycles after clear,
// then one pulse every CLKS_PER_BIT cycles.
module uart_rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_RX_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic sample
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;
  logic             first;

  // The first interval after clear is half a bit, landing on mid-bit.
  assign sample = (cnt == (first ? HALF_LAST : FULL_LAST));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt   <= '0;
      first <= 1'b1;
    end else if (sample) begin
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive deframer: start, 8 data bits LSB first, optional even parity
// (enabled by defining UART_RX_PARITY_EN), stop. rx_out holds the last good byte.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_RX_CLKS_PER_BIT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start_bit,
  input  logic                      stop_bit,
  input  logic                      data_in,
  input  logic                      parity,
  output logic [UART_RX_DATA_W-1:0] rx_out
);

`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
  localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

  uart_rx_state_t            state;
  uart_rx_state_t            state_nxt;
  logic                      start_prev;
  logic                      timer_clear;
  logic                      sample;
  logic                      shift_en;
  logic                      par_en;
  logic                      load_en;
  logic [2:0]                bit_idx;
  logic                      par_err;
  logic [UART_RX_DATA_W-1:0] shift_reg;

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock (clock),
    .reset (reset),
    .clear (timer_clear),
    .sample(sample)
  );

  always_comb begin
    state_nxt   = state;
    timer_clear = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    load_en     = 1'b0;
    case (state)
      // start_prev starts at 0, so a line low out of reset is not an edge.
      IDLE: begin
        if (start_prev && !start_bit) begin
          state_nxt   = START;
          timer_clear = 1'b1;
        end
      end
      START: begin
        if (sample) state_nxt = start_bit ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nxt = AFTER_DATA;
        end
      end
      PARITY: begin
        if (sample) begin
          par_en    = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          load_en   = stop_bit && !par_err;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      start_prev <= 1'b0;
      bit_idx    <= 3'd0;
      par_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_prev <= start_bit;
      if (timer_clear) begin
        bit_idx <= 3'd0;
        par_err <= 1'b0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (par_en) par_err <= (^shift_reg) ^ parity;
    end
  end

  // Bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg <= '0;
      rx_out    <= '0;
    end else begin
      if (shift_en) shift_reg <= {data_in, shift_reg[UART_RX_DATA_W-1:1]};
      if (load_en)  rx_out    <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frame table, corner-case
// sequences and randomized noisy frames against a frame-level reference model.
module tb_uart_rx_core;
  import uart_rx_pkg::*;

  localparam int CPB = UART_RX_CLKS_PER_BIT;
  localparam int H   = CPB / 2;
  localparam int N   = CPB;
`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam int STOP_W = PEN ? 10 : 9;
  localparam int LAST_K = STOP_W * N + H;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_bit;
  logic       stop_bit;
  logic       data_in;
  logic       parity;
  logic [7:0] rx_out;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_rx;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stp;
    bit         ok;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];

  always #5 clock = ~clock;

  uart_rx_core #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start_bit(start_bit),
    .stop_bit (stop_bit),
    .data_in  (data_in),
    .parity   (parity),
    .rx_out   (rx_out)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    checks++;
    if (rx_out !== exp) begin
      errors++;
      $display("FAIL %s: rx_out=%h expected %h at %0t", name, rx_out, exp, $time);
    end
  endtask

  // Frame-level rule: a byte is accepted only after a genuine start, a high
  // stop, and (when parity is enabled) a parity bit equal to the data XOR.
  function automatic logic [7:0] model(input logic [7:0] prev, input logic [7:0] d,
                                       input logic par, input logic stp, input bit ok);
    if (!ok || !stp) return prev;
    if (PEN && (par != ^d)) return prev;
    return d;
  endfunction

  // Drives one frame. k counts edges after the start-detection edge (k=0).
  // With noise set, every line toggles randomly except at its sample point.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                           input logic stp, input bit ok, input bit noise, input int abort_k);
    logic [7:0] nxt;
    int         last;
    int         w;
    bit         at_sample;
    nxt = model(exp_rx, d, par, stp, ok);
    last = ok ? LAST_K : H;
    start_bit = 1'b1;
    tick;
    for (int k = 0; k <= last; k++) begin
      w = k / N;
      at_sample = ((k % N) == H);
      if (k == 0) start_bit = 1'b0;
      else if (!ok) start_bit = (k < 2) ? 1'b0 : 1'b1;
      else if (k == H) start_bit = 1'b0;
      else if (noise) start_bit = 1'($urandom_range(0, 1));
      if (noise && !at_sample) begin
        data_in  = 1'($urandom_range(0, 1));
        parity   = 1'($urandom_range(0, 1));
        stop_bit = 1'($urandom_range(0, 1));
      end else if (w >= 1 && w <= 8) begin
        data_in = d[w-1];
      end else if (PEN && w == 9) begin
        parity = par;
      end else if (w == STOP_W) begin
        stop_bit = stp;
      end
      if (k == abort_k) reset = 1'b1;
      tick;
      if (k == abort_k) begin
        reset  = 1'b0;
        exp_rx = 8'h00;
        check({tag, "_reset"}, exp_rx);
        return;
      end
      if (k == last) begin
        exp_rx = nxt;
        check({tag, "_end"}, exp_rx);
      end else begin
        check({tag, "_hold"}, exp_rx);
      end
    end
  endtask

  // Keeps start_bit low with a payload that would load 8'hFF if a frame opened.
  task automatic hold_low(input string tag, input int cycles);
    start_bit = 1'b0;
    data_in   = 1'b1;
    parity    = 1'b0;
    stop_bit  = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      tick;
      check(tag, exp_rx);
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic       rp;

    tbl[0] = '{8'hED, 1'b0, 1'b1, 1'b1, 8'hED};
    tbl[1] = '{8'h81, 1'b1, 1'b1, 1'b1, PEN ? 8'hED : 8'h81};
    tbl[2] = '{8'hED, 1'b1, 1'b1, 1'b1, 8'hED};
    tbl[3] = '{8'h42, 1'b0, 1'b0, 1'b1, 8'hED};
    tbl[4] = '{8'h77, 1'b0, 1'b1, 1'b0, 8'hED};
    tbl[5] = '{8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A};
    tbl[6] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00};
    tbl[7] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF};
    tbl[8] = '{8'h01, 1'b0, 1'b1, 1'b1, PEN ? 8'hFF : 8'h01};
    tbl[9] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'h80};

    reset     = 1'b1;
    start_bit = 1'b1;
    stop_bit  = 1'b1;
    data_in   = 1'b0;
    parity    = 1'b0;
    exp_rx    = 8'h00;
    tick;
    tick;
    check("reset_value", 8'h00);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick;
      check("idle_after_reset", 8'h00);
    end

    start_bit = 1'b0;
    reset     = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    hold_low("low_from_reset", 100);

    for (int i = 0; i < 10; i++) begin
      run_frame($sformatf("tbl%0d", i), tbl[i].d, tbl[i].par, tbl[i].stp, tbl[i].ok, 1'b0, -1);
      check($sformatf("tbl%0d_const", i), tbl[i].exp);
      if (i == 0) hold_low("no_retrigger", 100);
    end

    run_frame("abort", 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, H + 5 * N);
    run_frame("after_abort", 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    check("after_abort_const", 8'h3C);

    for (int r = 0; r < 40; r++) begin
      rd = 8'($urandom_range(0, 255));
      rp = ^rd;
      if ($urandom_range(0, 3) == 0) rp = ~rp;
      run_frame($sformatf("rand%0d", r), rd, rp, 1'($urandom_range(0, 4) != 0),
                $urandom_range(0, 5) != 0, 1'b1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

UART receive block that deframes one serial character per frame into an 8-bit parallel byte. The line is split into four qualified inputs: start marker, serial data, parity and stop marker. Each is sampled at mid-bit by an internal bit timer. The block sits behind the UART pin/line-conditioning logic and feeds the byte register `rx_out` to the host-side datapath.

## Interface
- `CLKS_PER_BIT`, default 8: clock cycles per bit period; must be even and ≥ 4.
- `clock` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high; one clock and a synchronous active-high reset.
- `start_bit` input 1: start marker; its 1→0 transition opens a frame.
- `stop_bit` input 1: stop marker; must be 1 at the stop sample point.
- `data_in` input 1: serial data, LSB first.
- `parity` input 1: received parity bit (even parity).
- `rx_out` output 8: last correctly received byte; holds between frames.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- A registered `start_prev` resets to 0. It captures `start_bit` every cycle.
- IDLE → START when `start_prev`=1 and `start_bit`=0, i.e. a falling edge. This edge is cycle 0.
- A `start_bit` held low from reset never opens a frame. The line must first be sampled high.
- START: at cycle `CLKS_PER_BIT/2`, re-sample `start_bit`.
  - 0 → DATA.
  - 1 → false start; go to IDLE and leave `rx_out` unchanged.
- DATA: sample `data_in` every `CLKS_PER_BIT` cycles, 8 times, into a shift register, LSB first. Then go to PARITY.
- PARITY: sample `parity` and compare it with the XOR of the 8 data bits. Mismatch sets an internal `par_err` flag. Then go to STOP.
- STOP: sample `stop_bit`.
  - If it is 1 and `par_err`=0, load the shift register into `rx_out`.
  - Otherwise discard the byte.
  - Return to IDLE either way.
- `start_bit` is not re-checked after the start sample.
- A new frame requires a fresh 1→0 edge. A `start_bit` still low after STOP does not re-trigger.

## Timing
- Reset: `rx_out`=8'h00, state=IDLE, bit timer=0, shift register=0, `par_err`=0, `start_prev`=0.
- Reset asserted mid-frame aborts the frame on that edge with the same values.
- Sample points, relative to cycle 0 and with H=`CLKS_PER_BIT/2`, N=`CLKS_PER_BIT`:
  - start check at H;
  - data bit i (i = 0..7) at H+N·(i+1);
  - parity at H+9N;
  - stop at H+10N.
- `rx_out` is registered on the stop-sample edge and visible from the next cycle. Latency is H+10N+1 cycles from start detection; with defaults that is 85.
- Inputs are sampled only at these points. Glitches between them are ignored.

## Configuration
- `UART_RX_PARITY_EN` defined: parity slot present and even-parity checked as above.
- `UART_RX_PARITY_EN` undefined:
  - the `parity` input is ignored;
  - the frame has no parity slot;
  - stop is sampled at H+9N;
  - `rx_out` loads on a valid stop alone.
- The port list is identical in both cases.

## Structure
- Package `uart_rx_pkg` holds:
  - the state enum `uart_rx_state_t`;
  - the data width constant `UART_RX_DATA_W` = 8;
  - the default `CLKS_PER_BIT`.
- Sub-module `uart_rx_bit_timer` is a mid-bit/full-bit tick counter. It is cleared on start detection and produces a one-cycle `sample` pulse at H, then every N.

## Test plan
- Reset for 2 clocks with `start_bit`=1, then idle → `rx_out`=8'h00, state stays IDLE.
- `start_bit` 1→0 (held low), then 8 bits of 8 clocks each, LSB first, `data_in`=1,0,1,1,0,1,1,1, `parity`=0, `stop_bit`=1 → `rx_out`=8'hED at cycle 85 and held. No second frame while `start_bit` stays low.
- Same frame with `parity`=1 (parity enabled) → `rx_out` keeps its previous value.
- Same frame with `stop_bit`=0 at the stop sample → `rx_out` unchanged.
- `start_bit` low for 2 clocks then high (false start) → back to IDLE, `rx_out` unchanged. A following valid frame of 8'h5A with `parity`=0 → `rx_out`=8'h5A.
- Reset asserted at data bit 4 → `rx_out`=8'h00 on the next cycle. A subsequent full frame of 8'h3C is received correctly.
